// File: rtl/bnn_layer_sequencer_if.sv
// bnn_layer_sequencer_if: control and memory-bank bundle of the BNN sequencer.
// abort/aborted exist only when BNN_ABORT_EN is defined.
interface bnn_layer_sequencer_if #(
  parameter int LANES      = 8,
  parameter int LEN_W      = 16,
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int SEL_LEN    = 2
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [LEN_W-1:0]      result;
  logic                  w_rq;
  logic [SEL_LEN-1:0]    w_sel;
  logic [W_ADDR_LEN-1:0] w_addr;
  logic [LANES-1:0]      w_data;
  logic                  x_rq;
  logic                  x_wq;
  logic [SEL_LEN-1:0]    x_sel;
  logic [X_ADDR_LEN-1:0] x_addr;
  logic [LANES-1:0]      x_rdata;
  logic                  x_wdata;
`ifdef BNN_ABORT_EN
  logic                  abort;
  logic                  aborted;
`endif

  modport master (
`ifdef BNN_ABORT_EN
    input  abort,
    output aborted,
`endif
    input  start, w_data, x_rdata,
    output busy, done, result,
    output w_rq, w_sel, w_addr,
    output x_rq, x_wq, x_sel, x_addr, x_wdata
  );

  modport slave (
`ifdef BNN_ABORT_EN
    output abort,
    input  aborted,
`endif
    output start, w_data, x_rdata,
    input  busy, done, result,
    input  w_rq, w_sel, w_addr,
    input  x_rq, x_wq, x_sel, x_addr, x_wdata
  );
endinterface

// File: rtl/bnn_layer_sequencer.sv
// bnn_layer_sequencer: multi-layer XNOR-popcount binary NN sequencer.
// Optional abort/aborted port pair is enabled by defining BNN_ABORT_EN.
module bnn_layer_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int LANES      = 8,
  parameter int ACC_W      = 12,
  parameter int LEN_W      = 16,
  parameter logic [NUM_LAYERS*LEN_W-1:0] LAYER_IN =
    {16'd1024, 16'd1024, 16'd1024, 16'd784},
  parameter logic [NUM_LAYERS*LEN_W-1:0] LAYER_OUT =
    {16'd10, 16'd1024, 16'd1024, 16'd1024},
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int SEL_LEN    = 2
) (
  input logic clk,
  input logic rst,
  bnn_layer_sequencer_if.master bus
);

  localparam int LW1 = LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_EMIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [SEL_LEN-1:0]    layer_q, layer_d;
  logic [LEN_W-1:0]      n_q, n_d;
  logic [LEN_W-1:0]      b_q, b_d;
  logic [W_ADDR_LEN-1:0] waddr_q, waddr_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [ACC_W-1:0]      best_q, best_d;
  logic [LEN_W-1:0]      bidx_q, bidx_d;
  logic [LEN_W-1:0]      result_q, result_d;
  logic                  dv_q, dv_d;
  logic                  dtail_q, dtail_d;
`ifdef BNN_ABORT_EN
  logic                  aborted_q, aborted_d;
`endif

  logic [LEN_W-1:0] in_tab  [NUM_LAYERS];
  logic [LEN_W-1:0] out_tab [NUM_LAYERS];

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_tab
    assign in_tab[g]  = LAYER_IN[g*LEN_W +: LEN_W];
    assign out_tab[g] = LAYER_OUT[g*LEN_W +: LEN_W];
  end

  logic [LEN_W-1:0] in_len;
  logic [LEN_W-1:0] out_len;
  logic [LEN_W-1:0] beats;
  logic [LEN_W-1:0] rem;
  logic             is_last;
  logic             last_b;
  logic             last_n;
  logic             win;
  logic             hid_bit;
  logic             busy_w;
  logic             emit_wr;
  logic [LANES-1:0] lane_mask;
  logic [LANES-1:0] agree;
  logic [ACC_W-1:0] pop;

  assign in_len  = in_tab[layer_q];
  assign out_len = out_tab[layer_q];
  assign beats   = LEN_W'((32'(in_len) + LANES - 1) / LANES);
  assign rem     = LEN_W'(32'(in_len) % LANES);
  assign is_last = layer_q == SEL_LEN'(NUM_LAYERS - 1);
  assign last_b  = b_q == beats - 1'b1;
  assign last_n  = n_q == out_len - 1'b1;
  assign win     = (n_q == '0) || (acc_q > best_q);
  assign hid_bit = LW1'({acc_q, 1'b0}) >= LW1'(in_len);
  assign busy_w  = state_q inside {S_FETCH, S_DRAIN, S_EMIT, S_NEXT};
  assign emit_wr = (state_q == S_EMIT) && !is_last;

  assign bus.busy    = busy_w;
  assign bus.done    = state_q == S_DONE;
  assign bus.result  = result_q;
  assign bus.w_rq    = state_q == S_FETCH;
  assign bus.x_rq    = state_q == S_FETCH;
  assign bus.w_sel   = layer_q;
  assign bus.w_addr  = waddr_q;
  assign bus.x_wq    = emit_wr;
  assign bus.x_sel   = emit_wr ? layer_q + 1'b1 : layer_q;
  assign bus.x_addr  = emit_wr ? n_q[X_ADDR_LEN-1:0]
                               : b_q[X_ADDR_LEN-1:0];
  assign bus.x_wdata = emit_wr && hid_bit;
`ifdef BNN_ABORT_EN
  assign bus.aborted = aborted_q;
`endif

  // tail beat keeps only the lanes that hold real inputs
  always_comb begin
    lane_mask = '1;
    if (dtail_q && rem != '0) begin
      for (int i = 0; i < LANES; i++) begin
        lane_mask[i] = LEN_W'(i) < rem;
      end
    end
  end

  // XNOR agreement count of the returning beat
  always_comb begin
    pop   = '0;
    agree = ~(bus.w_data ^ bus.x_rdata) & lane_mask;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + ACC_W'(agree[i]);
    end
  end

  // sequencer next state, counters, accumulator and argmax
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    n_d      = n_q;
    b_d      = b_q;
    waddr_d  = waddr_q;
    acc_d    = dv_q ? acc_q + pop : acc_q;
    best_d   = best_q;
    bidx_d   = bidx_q;
    result_d = result_q;
    dv_d     = 1'b0;
    dtail_d  = 1'b0;
`ifdef BNN_ABORT_EN
    aborted_d = aborted_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          layer_d = '0;
          n_d     = '0;
          b_d     = '0;
          waddr_d = '0;
          acc_d   = '0;
`ifdef BNN_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        dv_d    = 1'b1;
        dtail_d = last_b;
        waddr_d = waddr_q + 1'b1;
        b_d     = last_b ? '0 : b_q + 1'b1;
        if (last_b) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_EMIT;
      S_EMIT: begin
        acc_d = '0;
        if (is_last && win) begin
          best_d = acc_q;
          bidx_d = n_q;
        end
        if (!last_n) begin
          n_d     = n_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          n_d = '0;
          if (is_last) begin
            state_d  = S_DONE;
            result_d = win ? n_q : bidx_q;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        layer_d = layer_q + 1'b1;
        waddr_d = '0;
        state_d = S_FETCH;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef BNN_ABORT_EN
    if (bus.abort && busy_w) begin
      state_d   = S_IDLE;
      result_d  = result_q;
      dv_d      = 1'b0;
      aborted_d = 1'b1;
    end
`endif
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      layer_q  <= '0;
      n_q      <= '0;
      b_q      <= '0;
      waddr_q  <= '0;
      acc_q    <= '0;
      best_q   <= '0;
      bidx_q   <= '0;
      result_q <= '0;
      dv_q     <= 1'b0;
      dtail_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      n_q      <= n_d;
      b_q      <= b_d;
      waddr_q  <= waddr_d;
      acc_q    <= acc_d;
      best_q   <= best_d;
      bidx_q   <= bidx_d;
      result_q <= result_d;
      dv_q     <= dv_d;
      dtail_q  <= dtail_d;
    end
  end

`ifdef BNN_ABORT_EN
  // sticky abort flag, cleared by the next accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) aborted_q <= 1'b0;
    else      aborted_q <= aborted_d;
  end
`endif

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// tb_bnn_layer_sequencer: directed and randomized runs of the BNN sequencer
// against a bit-level reference model of the layer equations.
module tb_bnn_layer_sequencer;

  localparam int NL    = 4;
  localparam int LANES = 8;
  localparam int IN_T  [NL] = '{20, 16, 12, 13};
  localparam int OUT_T [NL] = '{16, 12, 13, 4};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bnn_layer_sequencer_if #(
    .LANES(8), .LEN_W(16), .W_ADDR_LEN(20),
    .X_ADDR_LEN(10), .SEL_LEN(2)
  ) ifc ();

  bnn_layer_sequencer #(
    .NUM_LAYERS(4), .LANES(8), .ACC_W(12), .LEN_W(16),
    .LAYER_IN({16'd13, 16'd12, 16'd16, 16'd20}),
    .LAYER_OUT({16'd4, 16'd13, 16'd12, 16'd16}),
    .W_ADDR_LEN(20), .X_ADDR_LEN(10), .SEL_LEN(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  wm   [NL][64];
  logic [63:0] xm   [NL];
  logic [63:0] gold [NL];
  int          sc_tab [NL][16];
  int exp_L = 0, exp_res = 0, exp_wr = 0, exp_rq = 0;

  bit m_act = 0;
  bit m_abt = 0;
  int t = 0, nwr = 0, nrq = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // memory banks: one-cycle read latency, garbage when not requested
  always @(posedge clk) begin
    ifc.w_data  <= ifc.w_rq ? wm[ifc.w_sel][ifc.w_addr[5:0]]
                            : 8'($urandom);
    ifc.x_rdata <= ifc.x_rq ? xm[ifc.x_sel][ifc.x_addr[2:0]*8 +: 8]
                            : 8'($urandom);
    if (ifc.x_wq) xm[ifc.x_sel][ifc.x_addr[5:0]] <= ifc.x_wdata;
  end

  // run timeline of the reference: t counts cycles since accepted start
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act = 0;
      m_abt = 0;
      t     = 0;
    end else if (m_act) begin
`ifdef BNN_ABORT_EN
      if (ifc.abort && t < exp_L) begin
        m_act = 0;
        m_abt = 1;
      end else
`endif
      if (t == exp_L) m_act = 0;
      else t++;
    end else if (ifc.start) begin
      m_act = 1;
      m_abt = 0;
      t     = 1;
      nwr   = 0;
      nrq   = 0;
    end
  end

  // per-cycle comparison against the reference timeline and golden banks
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_busy", ifc.busy, 0);
      check("rst_done", ifc.done, 0);
      check("rst_rq", {ifc.w_rq, ifc.x_rq, ifc.x_wq}, 0);
      check("rst_result", ifc.result, 0);
    end else begin
      check("busy", ifc.busy, m_act && t < exp_L);
      check("done", ifc.done, m_act && t == exp_L);
      check("rq_pair", ifc.w_rq, ifc.x_rq);
      if (ifc.w_rq) nrq++;
      if (ifc.x_wq) begin
        nwr++;
        check("wr_sel", ifc.x_sel >= 1 && ifc.x_sel < NL, 1);
        check("wr_bit", ifc.x_wdata,
              gold[ifc.x_sel][ifc.x_addr[5:0]]);
      end
      if (m_act && t == exp_L) begin
        check("result", ifc.result, exp_res);
        check("n_writes", nwr, exp_wr);
        check("n_reads", nrq, exp_rq);
      end
`ifdef BNN_ABORT_EN
      check("aborted", ifc.aborted, m_abt);
`endif
    end
  end

  task automatic build_model();
    logic [63:0] cur, nxt;
    int bt, sc, best, sum;
    cur = xm[0];
    gold[0] = xm[0];
    sum = 0; best = 0; exp_res = 0; exp_wr = 0; exp_rq = 0;
    for (int k = 0; k < NL; k++) begin
      bt = (IN_T[k] + LANES - 1) / LANES;
      sum += OUT_T[k] * (bt + 2);
      exp_rq += OUT_T[k] * bt;
      nxt = '0;
      for (int n = 0; n < OUT_T[k]; n++) begin
        sc = 0;
        for (int i = 0; i < IN_T[k]; i++)
          if (wm[k][n*bt + i/LANES][i%LANES] == cur[i]) sc++;
        sc_tab[k][n] = sc;
        if (k < NL - 1) nxt[n] = (2 * sc >= IN_T[k]);
        else if (n == 0 || sc > best) begin
          best = sc;
          exp_res = n;
        end
      end
      if (k < NL - 1) begin
        gold[k+1] = nxt;
        exp_wr += OUT_T[k];
      end
      cur = nxt;
    end
    exp_L = sum + NL;
  endtask

  // mode 0 random, 1 argmax pattern, 2 zero weights, 3 threshold ramp
  task automatic prep(input int mode);
    logic [11:0] r;
    for (int k = 0; k < NL; k++)
      for (int a = 0; a < 64; a++)
        wm[k][a] = (mode == 0) ? 8'($urandom) :
                   (mode == 2) ? 8'h00 : 8'hFF;
    if (mode == 1) begin
      wm[3][0] = 8'h07; wm[3][1] = 8'hE0;
      wm[3][2] = 8'h7F; wm[3][3] = 8'hE0;
      wm[3][4] = 8'h3F; wm[3][5] = 8'hE1;
      wm[3][6] = 8'h03; wm[3][7] = 8'hE0;
    end
    if (mode == 3) begin
      for (int n = 0; n < 13; n++) begin
        r = 12'((1 << n) - 1);
        wm[2][2*n]   = r[7:0];
        wm[2][2*n+1] = {4'hF, r[11:8]};
      end
    end
    xm[0] <= (mode == 0) ? {$urandom, $urandom}
                         : ({$urandom, $urandom} | 64'hFFFFF);
    for (int k = 1; k < NL; k++) xm[k] <= {$urandom, $urandom};
    @(negedge clk);
    build_model();
  endtask

  task automatic run(input string tag, input bit mid);
    int k;
    logic [63:0] m;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    k = 0;
    while (ifc.done !== 1'b1 && k < 600) begin
      @(negedge clk);
      k++;
      ifc.start = (mid && k == 30);
    end
    ifc.start = 1'b0;
    check({tag, "_done_seen"}, ifc.done, 1);
    @(negedge clk);
    check({tag, "_held"}, ifc.result, exp_res);
    for (int b = 1; b < NL; b++) begin
      m = (64'd1 << OUT_T[b-1]) - 1;
      check({tag, "_bank"}, xm[b] & m, gold[b] & m);
    end
  endtask

  initial begin
    logic [15:0] saved;
    ifc.start = 1'b0;
`ifdef BNN_ABORT_EN
    ifc.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    prep(1);
    check("pinA_res", exp_res, 1);
    check("pinA_s0", sc_tab[3][0], 3);
    check("pinA_s1", sc_tab[3][1], 7);
    check("pinA_s2", sc_tab[3][2], 7);
    check("pinA_s3", sc_tab[3][3], 2);
    check("pinA_len", exp_L, 200);
    check("pinA_x1", gold[1][15:0], 16'hFFFF);
    run("argmax", 0);

    prep(2);
    check("pinB_x1", gold[1][15:0], 16'h0000);
    check("pinB_x2", gold[2][11:0], 12'hFFF);
    check("pinB_x3", gold[3][12:0], 13'h0000);
    check("pinB_s3", sc_tab[3][2], 13);
    check("pinB_res", exp_res, 0);
    run("zeros", 0);

    prep(3);
    check("pinC_s5", sc_tab[2][5], 5);
    check("pinC_s6", sc_tab[2][6], 6);
    check("pinC_x3", gold[3][12:0], 13'h1FC0);
    run("thresh", 0);

    for (int r = 0; r < 10; r++) begin
      prep(0);
      run("rand", r == 3);
    end

    prep(0);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (140) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", ifc.busy, 0);
    check("arst_done", ifc.done, 0);
    check("arst_rq", {ifc.w_rq, ifc.x_rq, ifc.x_wq}, 0);
    check("arst_result", ifc.result, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    prep(0);
    run("post_rst", 0);

`ifdef BNN_ABORT_EN
    saved = ifc.result;
    prep(0);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (90) @(negedge clk);
    ifc.abort = 1'b1;
    @(negedge clk);
    ifc.abort = 1'b0;
    check("abt_flag", ifc.aborted, 1);
    check("abt_busy", ifc.busy, 0);
    repeat (4) @(negedge clk);
    check("abt_result", ifc.result, {48'd0, saved});
    ifc.abort = 1'b1;
    @(negedge clk);
    ifc.abort = 1'b0;
    prep(0);
    run("post_abt", 0);
`else
    saved = ifc.result;
    check("final_held", ifc.result, {48'd0, saved});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
